// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT address generator.
// Holds the sequencer state encoding and the bit-rotate used for DIT addressing.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } agu_state_t;

    localparam int N_LOG2_DEF   = 5;
    localparam int BFLY_LAT_DEF = 2;

    // Rotate the low `width` bits of value left by amount; upper bits read 0.
    function automatic logic [31:0] rotl(
        input logic [31:0] value,
        input int unsigned amount,
        input int unsigned width
    );
        logic [31:0] r;
        int unsigned sh;
        r  = '0;
        sh = amount % width;
        for (int k = 0; k < 32; k++) begin
            if (k < int'(width)) begin
                r[k] = value[5'((k + width - sh) % width)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_agu_if.sv
// Controller handshake plus read/write address bus of the FFT AGU.
// master is the AGU side, slave is the controller/datapath side.
interface fft_agu_if
    import fft_pkg::*;
#(
    parameter int N_LOG2 = N_LOG2_DEF
);

    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic              rd_bank;
    logic [N_LOG2-1:0] adr_a;
    logic [N_LOG2-1:0] adr_b;
    logic [N_LOG2-2:0] tw_adr;
    logic              wr_en;
    logic              wr_bank;
    logic [N_LOG2-1:0] wr_adr_a;
    logic [N_LOG2-1:0] wr_adr_b;

    modport master (
        input  start,
        output busy, done,
        output rd_en, rd_bank, adr_a, adr_b, tw_adr,
        output wr_en, wr_bank, wr_adr_a, wr_adr_b
    );

    modport slave (
        output start,
        input  busy, done,
        input  rd_en, rd_bank, adr_a, adr_b, tw_adr,
        input  wr_en, wr_bank, wr_adr_a, wr_adr_b
    );

endinterface

// File: rtl/fft_agu_dly.sv
// Delay line matching the butterfly pipeline latency.
// Every stage clears on reset so in-flight butterflies never retire.
module fft_agu_dly #(
    parameter int W     = 5,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_in,
    input  logic         bank_in,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         valid_out,
    output logic         bank_out,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out
);

    localparam int SW = 2 * W + 2;

    logic [SW-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                sr[k] <= '0;
            end
        end else begin
            sr[0] <= {valid_in, bank_in, a_in, b_in};
            for (int k = 1; k < DEPTH; k++) begin
                sr[k] <= sr[k-1];
            end
        end
    end

    assign {valid_out, bank_out, a_out, b_out} = sr[DEPTH-1];

endmodule

// File: rtl/fft_agu.sv
// Radix-2 DIT in-place address sequencer with ping-pong banks.
// Issues one butterfly per cycle, then drains the pipeline before each level.
module fft_agu
    import fft_pkg::*;
#(
    parameter int N_LOG2   = N_LOG2_DEF,
    parameter int BFLY_LAT = BFLY_LAT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    fft_agu_if.master      bus
);

    localparam int LVL_W = $clog2(N_LOG2 + 1);
    localparam int CNT_W = $clog2(BFLY_LAT + 1);

    agu_state_t        state;
    logic [LVL_W-1:0]  level;
    logic [N_LOG2-2:0] idx;
    logic [CNT_W-1:0]  cnt;
    logic              bank;

    logic              run;
    logic [N_LOG2-1:0] j_a;
    logic [N_LOG2-1:0] j_b;
    logic [31:0]       rot_a;
    logic [31:0]       rot_b;
    logic [N_LOG2-1:0] adr_a;
    logic [N_LOG2-1:0] adr_b;
    logic [N_LOG2-2:0] tw_mask;
    logic              unused_rot;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            level <= '0;
            idx   <= '0;
            cnt   <= '0;
            bank  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= RUN;
                        level <= '0;
                        idx   <= '0;
                        cnt   <= '0;
                        bank  <= 1'b0;
                    end
                end
                RUN: begin
                    idx <= idx + 1'b1;
                    if (&idx) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end
                end
                DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(BFLY_LAT - 1)) begin
                        cnt <= '0;
                        if (level == LVL_W'(N_LOG2 - 1)) begin
                            state <= DONE;
                        end else begin
                            state <= RUN;
                            level <= level + 1'b1;
                            idx   <= '0;
                            bank  <= ~bank;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign run = (state == RUN);
    assign j_a = {idx, 1'b0};
    assign j_b = {idx, 1'b1};

    assign rot_a = rotl(32'(j_a), 32'(level), N_LOG2);
    assign rot_b = rotl(32'(j_b), 32'(level), N_LOG2);
    assign unused_rot = ^{rot_a[31:N_LOG2], rot_b[31:N_LOG2]};

    // Twiddle index keeps only the top `level` bits of the butterfly index.
    assign tw_mask = {(N_LOG2-1){1'b1}} << (LVL_W'(N_LOG2 - 1) - level);

    assign adr_a = run ? rot_a[N_LOG2-1:0] : '0;
    assign adr_b = run ? rot_b[N_LOG2-1:0] : '0;

    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.rd_en   = run;
    assign bus.rd_bank = bank;
    assign bus.adr_a   = adr_a;
    assign bus.adr_b   = adr_b;
    assign bus.tw_adr  = run ? (tw_mask & idx) : '0;

    fft_agu_dly #(
        .W     (N_LOG2),
        .DEPTH (BFLY_LAT)
    ) u_dly (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (run),
        .bank_in   (run & ~bank),
        .a_in      (adr_a),
        .b_in      (adr_b),
        .valid_out (bus.wr_en),
        .bank_out  (bus.wr_bank),
        .a_out     (bus.wr_adr_a),
        .b_out     (bus.wr_adr_b)
    );

endmodule

// File: tb/tb_fft_agu.sv
// Bench for fft_agu: per-cycle comparison against a schedule model
// derived from level/butterfly arithmetic, with random start noise and aborts.
module tb_fft_agu;

    localparam int NL       = 5;
    localparam int LAT      = 2;
    localparam int HALF     = 1 << (NL - 1);
    localparam int LVL_CYC  = HALF + LAT;
    localparam int DONE_CYC = 1 + NL * LVL_CYC;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          rd_en;
        logic          rd_bank;
        logic [NL-1:0] a;
        logic [NL-1:0] b;
        logic [NL-2:0] tw;
        logic          wr_en;
        logic          wr_bank;
        logic [NL-1:0] wa;
        logic [NL-1:0] wb;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    fft_agu_if #(.N_LOG2(NL)) bus ();

    fft_agu #(
        .N_LOG2   (NL),
        .BFLY_LAT (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rel = 0;
    int n_rd, n_wr, n_done, n_busy;
    logic [31:0] cov [NL];

    function automatic logic [NL-1:0] rot(input int v, input int s);
        int mask;
        mask = (1 << NL) - 1;
        return NL'(((v << s) | (v >> (NL - s))) & mask);
    endfunction

    // Expected outputs for cycle c of a transform (c==0: idle).
    function automatic obs_t model(input int c);
        obs_t o;
        int base, i, msk;
        o = '0;
        if (c == 0) return o;
        o.busy = 1'b1;
        o.done = (c == DONE_CYC);
        for (int l = 0; l < NL; l++) begin
            base = 1 + l * LVL_CYC;
            if (c >= base && c < base + LVL_CYC)
                o.rd_bank = ((l % 2) != 0);
            if (c >= base && c < base + HALF) begin
                i = c - base;
                msk = ((HALF - 1) << (NL - 1 - l)) & (HALF - 1);
                o.rd_en = 1'b1;
                o.a = rot(2 * i, l);
                o.b = rot(2 * i + 1, l);
                o.tw = (NL-1)'(i & msk);
            end
            if (c >= base + LAT && c < base + LAT + HALF) begin
                i = c - base - LAT;
                o.wr_en = 1'b1;
                o.wr_bank = ((l % 2) == 0);
                o.wa = rot(2 * i, l);
                o.wb = rot(2 * i + 1, l);
            end
        end
        return o;
    endfunction

    task automatic clear_stats();
        n_rd = 0;
        n_wr = 0;
        n_done = 0;
        n_busy = 0;
        for (int l = 0; l < NL; l++) cov[l] = '0;
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input logic st, input logic rst);
        obs_t got, exp;
        int lvl;
        bus.start = st;
        reset = rst;
        @(posedge clk);
        if (!rst) rel = 0;
        else if (rel == 0) rel = st ? 1 : 0;
        else if (rel == DONE_CYC) rel = 0;
        else rel++;
        @(negedge clk);
        got.busy    = bus.busy;
        got.done    = bus.done;
        got.rd_en   = bus.rd_en;
        got.rd_bank = bus.rd_bank;
        got.a       = bus.adr_a;
        got.b       = bus.adr_b;
        got.tw      = bus.tw_adr;
        got.wr_en   = bus.wr_en;
        got.wr_bank = bus.wr_bank;
        got.wa      = bus.wr_adr_a;
        got.wb      = bus.wr_adr_b;
        exp = model(rel);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL cyc%0d got=%h exp=%h", rel, got, exp);
        end
        if (got.rd_en === 1'b1) begin
            n_rd++;
            lvl = (rel > 0) ? (rel - 1) / LVL_CYC : NL;
            if (lvl < NL)
                cov[lvl] = cov[lvl] | (32'h1 << got.a) | (32'h1 << got.b);
        end
        if (got.wr_en === 1'b1) n_wr++;
        if (got.done === 1'b1) n_done++;
        if (got.busy === 1'b1) n_busy++;
    endtask

    task automatic run_to(input int stop_rel);
        int guard;
        logic st;
        guard = 0;
        while (rel != 0 && rel < stop_rel && guard < 200) begin
            st = (rel == 10) || (rel == DONE_CYC) || ($urandom_range(0, 5) == 0);
            tick(st, 1'b1);
            guard++;
        end
        check_int("run_bound", int'(guard < 200), 1);
    endtask

    task automatic full_run_stats();
        check_int("rd_count", n_rd, NL * HALF);
        check_int("wr_count", n_wr, NL * HALF);
        check_int("done_pulses", n_done, 1);
        check_int("busy_cycles", n_busy, DONE_CYC);
        for (int l = 0; l < NL; l++)
            check_int($sformatf("cover_l%0d", l), int'(cov[l] == 32'hFFFF_FFFF), 1);
    endtask

    initial begin
        bus.start = 1'b0;
        clear_stats();

        repeat (3) tick(1'b0, 1'b0);
        repeat (8) tick(1'b0, 1'b1);
        check_int("idle_busy", n_busy, 0);

        repeat ($urandom_range(0, 3)) tick(1'b0, 1'b1);
        clear_stats();
        tick(1'b1, 1'b1);
        run_to(DONE_CYC + 10);
        full_run_stats();

        // Start in the first idle cycle after done begins a fresh transform.
        tick(1'b1, 1'b1);
        check_int("restart_rel", rel, 1);
        run_to(40);
        tick(1'b0, 1'b0);
        repeat (4) tick(1'b0, 1'b1);

        tick(1'b1, 1'b1);
        run_to(int'($urandom_range(2, DONE_CYC - 2)));
        tick(1'b0, 1'b0);
        repeat ($urandom_range(1, 4)) tick(1'b0, 1'b1);

        clear_stats();
        tick(1'b1, 1'b1);
        run_to(DONE_CYC + 10);
        full_run_stats();
        repeat (3) tick(1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
